// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg
//   Shared sizing for the weight-memory write path. The coprocessor's
//   parameters.vh sets the same values; they are mirrored here so the
//   loader can be elaborated on its own.
//   Contents:
//     DWIDTH_DEF    default weight word width (signed)
//     WSIZE_DEF     default weight memory address width
//     wrap_addr()   address of the i-th word after a base, modulo 2^WSIZE_DEF
package weight_loader_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int WSIZE_DEF  = 12;

    function automatic logic [WSIZE_DEF-1:0] wrap_addr(
        input logic [WSIZE_DEF-1:0] base,
        input logic [WSIZE_DEF-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/weight_loader.sv
// weight_loader
//   Streaming write front-end for mem_weight. A req in IDLE latches a base
//   address and a word count. Each accepted stream beat is written one cycle
//   later to the next consecutive address, wrapping modulo 2^WSIZE. ack
//   pulses for one cycle together with the last write.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for req; s_ready=0, busy=0
//   S_LOAD | accepting beats; s_ready=1, one write per accepted beat
//   S_DONE | single cycle; ack=1, carries the final write (if any)
//
//   Ports:
//     clk         system clock, rising edge
//     xrst        asynchronous active-low reset
//     req         start pulse, honoured only in S_IDLE
//     base_addr   first write address, latched on accepted req
//     total       word count 0..2^WSIZE, latched on accepted req
//     s_valid     stream word valid
//     s_data      stream word (signed)
//     s_ready     loader accepts a word this cycle
//     mem_we      memory write enable
//     mem_addr    memory write address
//     write_data  memory write data (signed)
//     busy        high whenever the FSM is not in S_IDLE
//     ack         one-cycle completion pulse
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int WSIZE  = WSIZE_DEF
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     req,
    input  logic [WSIZE-1:0]         base_addr,
    input  logic [WSIZE:0]           total,
    input  logic                     s_valid,
    input  logic signed [DWIDTH-1:0] s_data,
    output logic                     s_ready,
    output logic                     mem_we,
    output logic [WSIZE-1:0]         mem_addr,
    output logic signed [DWIDTH-1:0] write_data,
    output logic                     busy,
    output logic                     ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WSIZE-1:0]   addr_cnt;
    logic [WSIZE:0]     remaining;

    // Decoded from state alone so s_ready never depends on s_valid.
    assign s_ready = (state == S_LOAD);
    assign busy    = (state != S_IDLE);
    assign ack     = (state == S_DONE);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            addr_cnt   <= '0;
            remaining  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            write_data <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_cnt  <= base_addr;
                        remaining <= total;
                        state     <= (total == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr_cnt;
                        write_data <= s_data;
                        // Natural overflow of the WSIZE-bit counter gives the wrap.
                        addr_cnt   <= addr_cnt + 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == (WSIZE+1)'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader
//   Directed sequence with randomized data, bases and stream throttling.
//   The expected write stream is derived from the load request alone:
//   word i of a load goes to (base + i) mod 4096 one cycle after it is
//   accepted, and ack coincides with the final write.
module tb_weight_loader;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 xrst;
    logic                 req;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          total;
    logic                 s_valid;
    logic signed [DW-1:0] s_data;
    logic                 s_ready;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] write_data;
    logic                 busy;
    logic                 ack;

    weight_loader #(.DWIDTH(DW), .WSIZE(AW)) dut (
        .clk        (clk),
        .xrst       (xrst),
        .req        (req),
        .base_addr  (base_addr),
        .total      (total),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    // Stand-in for mem_weight: commits on the edge after mem_we is seen.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= write_data;
    end

    int total_n = 0;
    int bad_n   = 0;

    `define CHK(tag, obs, exp) \
        begin \
            total_n++; \
            assert ((obs) === (exp)) else begin \
                bad_n++; \
                $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
            end \
        end

    logic [DW-1:0] words[$];
    bit            pat[$];
    int            vmode;   // 0 continuous, 1 random, 2 pattern then continuous

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
    endtask

    // Runs one complete load starting at a negedge with the DUT idle.
    // glitch_at >= 0 pulses a bogus req in the cycle word glitch_at is offered.
    // req_in_done pulses a bogus req during the ack cycle.
    task automatic do_load(input int b, input int n, input int glitch_at, input bit req_in_done);
        int            acc = 0;
        int            pidx = 0;
        bit            pend = 0;
        bit            v;
        int            pat_i = 0;
        int            guard = 0;
        logic [AW-1:0] ea;
        logic [AW-1:0] bb;
        bb = AW'(b);
        req = 1'b1;
        base_addr = bb;
        total = (AW+1)'(n);
        s_valid = 1'($urandom);
        s_data = DW'($urandom);
        @(negedge clk);
        req = 1'b0;
        `CHK("busy_rise", busy, 1'b1)
        forever begin
            `CHK("s_ready", s_ready, (acc < n))
            `CHK("mem_we", mem_we, pend)
            if (pend) begin
                ea = bb + AW'(pidx);
                `CHK("mem_addr", mem_addr, ea)
                `CHK("write_data", write_data, words[pidx])
                ref_mem[ea] = words[pidx];
            end
            `CHK("ack", ack, (acc == n))
            if (acc == n) begin
                req = req_in_done;
                base_addr = AW'($urandom);
                total = 13'd5;
                s_valid = 1'b1;
                s_data = DW'($urandom);
                @(negedge clk);
                req = 1'b0;
                s_valid = 1'b0;
                `CHK("busy_fall", busy, 1'b0)
                `CHK("ack_fall", ack, 1'b0)
                `CHK("idle_we", mem_we, 1'b0)
                `CHK("idle_ready", s_ready, 1'b0)
                return;
            end
            if (vmode == 0) v = 1'b1;
            else if (vmode == 2) begin
                v = (pat_i < pat.size()) ? pat[pat_i] : 1'b1;
                pat_i++;
            end else v = ($urandom_range(99) < 60);
            s_valid = v;
            s_data = v ? words[acc] : DW'($urandom);
            if (acc == glitch_at) begin
                req = 1'b1;
                base_addr = AW'($urandom);
                total = (AW+1)'($urandom_range(20, 1));
            end else req = 1'b0;
            pend = v;
            pidx = acc;
            if (v) acc++;
            @(negedge clk);
            guard++;
            if (guard > 30000) begin
                `CHK("load_timeout", guard, 0)
                return;
            end
        end
    endtask

    int            rb;
    logic [DW-1:0] w0;
    logic [DW-1:0] old1;
    int            mism;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        xrst = 1'b0;
        req = 1'b0;
        base_addr = '0;
        total = '0;
        s_valid = 1'b0;
        s_data = '0;
        vmode = 0;
        #12;
        `CHK("rst_we", mem_we, 1'b0)
        `CHK("rst_addr", mem_addr, 12'h000)
        `CHK("rst_data", write_data, 16'h0000)
        `CHK("rst_ready", s_ready, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_ack", ack, 1'b0)
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        s_valid = 1'b1;
        @(negedge clk);
        `CHK("idle_no_consume", mem_we, 1'b0)
        s_valid = 1'b0;

        // Basic load with known words
        words.delete();
        words.push_back(16'sd5);
        words.push_back(-16'sd3);
        words.push_back(16'sd7);
        words.push_back(-16'sd1);
        vmode = 0;
        do_load(12'h010, 4, -1, 1'b0);
        @(negedge clk);
        `CHK("rb_010", mem[12'h010], 16'h0005)
        `CHK("rb_011", mem[12'h011], 16'hFFFD)
        `CHK("rb_012", mem[12'h012], 16'h0007)
        `CHK("rb_013", mem[12'h013], 16'hFFFF)

        // Throttled 1,0,0,1,0,1
        pat.delete();
        pat.push_back(1); pat.push_back(0); pat.push_back(0);
        pat.push_back(1); pat.push_back(0); pat.push_back(1);
        vmode = 2;
        fill_words(3);
        do_load($urandom_range(DEPTH-1), 3, -1, 1'b0);

        // Wrap-around
        vmode = 1;
        fill_words(4);
        do_load(12'hFFE, 4, -1, 1'b0);
        @(negedge clk);
        `CHK("wrap_ffe", mem[12'hFFE], words[0])
        `CHK("wrap_fff", mem[12'hFFF], words[1])
        `CHK("wrap_000", mem[12'h000], words[2])
        `CHK("wrap_001", mem[12'h001], words[3])

        // Zero length, with a req during the ack cycle
        words.delete();
        do_load($urandom_range(DEPTH-1), 0, -1, 1'b1);

        // req pulsed mid-load is ignored
        fill_words(8);
        do_load($urandom_range(DEPTH-1), 8, 3, 1'b0);

        // Reset after 2 of 6 beats
        fill_words(6);
        rb = $urandom_range(100, 3000);
        old1 = ref_mem[rb+1];
        req = 1'b1;
        base_addr = AW'(rb);
        total = 13'd6;
        @(negedge clk);
        req = 1'b0;
        s_valid = 1'b1;
        s_data = words[0];
        @(negedge clk);
        s_data = words[1];
        @(negedge clk);
        `CHK("pre_rst_we", mem_we, 1'b1)
        w0 = words[0];
        ref_mem[rb] = w0;
        xrst = 1'b0;
        #1;
        `CHK("mid_rst_we", mem_we, 1'b0)
        `CHK("mid_rst_addr", mem_addr, 12'h000)
        `CHK("mid_rst_data", write_data, 16'h0000)
        `CHK("mid_rst_ready", s_ready, 1'b0)
        `CHK("mid_rst_busy", busy, 1'b0)
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            `CHK("rst_no_ack", ack, 1'b0)
        end
        xrst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        `CHK("partial_w0", mem[rb], w0)
        `CHK("partial_w1", mem[rb+1], old1)
        fill_words(6);
        do_load($urandom_range(DEPTH-1), 6, -1, 1'b0);

        // Random short loads
        for (int k = 0; k < 5; k++) begin
            vmode = $urandom_range(1);
            rb = $urandom_range(12);
            fill_words(rb);
            do_load($urandom_range(DEPTH-1), rb, -1, 1'($urandom));
        end

        // Full-depth load
        vmode = 0;
        fill_words(DEPTH);
        do_load($urandom_range(DEPTH-1), DEPTH, -1, 1'b0);
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
        `CHK("mem_image", mism, 0)

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Streaming write front-end for the coprocessor weight memory (`mem_weight`). On a start request it accepts a run of weight words over a valid/ready stream from the host/DMA side. It writes them to consecutive memory addresses from a programmed base, drives the memory write port one cycle after each accepted beat, and pulses a completion flag when the last word has been written.

## Interface
Parameters (defaults come from `parameters.vh`):
- `DWIDTH`, 16: weight word width, signed.
- `WSIZE`, 12: weight memory address width; memory depth is 2^WSIZE.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `xrst`  in  1  reset, asynchronous and active-low.
- `req`  in  1  start pulse; sampled only in IDLE.
- `base_addr`  in  WSIZE  first write address; latched on accepted `req`.
- `total`  in  WSIZE+1  number of words to load, 0..2^WSIZE; latched on accepted `req`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DWIDTH  stream word, signed.
- `s_ready`  out  1  loader can accept a word.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  WSIZE  memory address.
- `write_data`  out  DWIDTH  memory write data, signed.
- `busy`  out  1  high while not in IDLE.
- `ack`  out  1  one-cycle completion pulse.

## Operation
- FSM states are S_IDLE, S_LOAD and S_DONE.
- S_IDLE:
  - `req`=1 latches `base_addr` into the address counter and `total` into the remaining counter.
  - If `total`≠0, go to S_LOAD; if `total`=0, go to S_DONE.
- S_LOAD:
  - `s_ready` = 1. It is combinational from state only and never depends on `s_valid`.
  - A beat is accepted on an edge where `s_valid`&&`s_ready`. On acceptance, register `s_data` into `write_data`, the current address into `mem_addr`, and set `mem_we`=1 for the next cycle.
  - Then increment the address and decrement the remaining counter.
  - Acceptance of the final beat (remaining = 1) moves the FSM to S_DONE.
- S_DONE lasts exactly one cycle, with `ack`=1, `s_ready`=0, `busy`=1. The next state is S_IDLE.
- Address arithmetic is modulo 2^WSIZE: base + count past the top wraps to 0, with no error flag. `total`=2^WSIZE overwrites the whole memory exactly once.
- `req` outside S_IDLE is ignored, with no queuing. `req` in the S_DONE cycle is also ignored.
- `s_valid` in S_IDLE or S_DONE is not consumed.
- Cycles with `s_valid`=0 in S_LOAD produce `mem_we`=0. Address and remaining count hold.

## Timing
- Reset values: state S_IDLE; `mem_we`=0, `mem_addr`=0, `write_data`=0, `s_ready`=0, `busy`=0, `ack`=0.
- Start latency: `req` at edge N gives `s_ready`=1 from cycle N+1.
- Write latency: a beat accepted at edge k gives `mem_we`=1 with its address and data during cycle k+1. The memory commits at edge k+2.
- Back-to-back beats give one write per cycle with no bubbles.
- The last word's `mem_we` coincides with `ack` in the S_DONE cycle. A read address presented to `mem_weight` in the cycle after `ack` returns the new data.
- `total`=0 produces `ack` one cycle after `req`, with no `mem_we` pulse.
- `busy` rises the cycle after `req` and falls the cycle after `ack`.
- Reset asserted mid-load:
  - Immediately forces the reset values, including `mem_we`=0.
  - Partially written words remain in memory.
  - No `ack` is issued.

## Structure
- `DWIDTH` and `WSIZE` come from the shared `parameters.vh`. State encodings are localparams inside the module; they are not shared.
- No sub-module is needed. The address and remaining counters are inline registers.
- The top-level coprocessor instantiates `weight_loader` and connects `mem_we`/`mem_addr`/`write_data` directly to `mem_weight`. The read side muxes `mem_addr` with the compute engine while `busy`=0.

## Test plan
- Basic load: base=0x010, total=4, words 5,-3,7,-1 with continuous `s_valid` → writes at 0x010..0x013 in 4 consecutive cycles; `ack` on the 4th write cycle; read-back matches.
- Throttled stream: total=3, `s_valid` pattern 1,0,0,1,0,1 → exactly 3 `mem_we` pulses at base..base+2, each one cycle after its accept; `ack` with the third.
- Wrap-around: WSIZE=12, base=0xFFE, total=4 → writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Zero length and ignored requests: total=0 → `ack` one cycle after `req`, no `mem_we`. A second `req` pulsed while in S_LOAD → no restart and counters unchanged.
- Reset mid-operation: deassert `xrst` after 2 of 6 beats → outputs return to reset values asynchronously, with no `ack`. A new `req` after release performs a full, correct load.
